mdu_div: RTL and testbench

- Parametrised sequential integer divider for the MIPS multiply/divide unit; serves DIV and DIVU.
- Uses a radix-2 non-restoring algorithm on operand magnitudes, one quotient bit per clock, then one final cycle for remainder correction and sign fix-up.
- Adds the following over the fixed 32-bit signed divider:
  - width parameter;
  - per-operation signed/unsigned mode;
  - registered, held results;
  - done pulse;
  - divide-by-zero early-out and flag;
  - abort input for pipeline flush on exceptions.

---
 rtl/mdu_div.sv | 205 ++++++++++++++++++++
 tb/tb_mdu_div.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_div.sv
// Sequential radix-2 non-restoring divider for the MIPS multiply/divide unit (DIV/DIVU).
// One quotient bit per clock on operand magnitudes, then one cycle of remainder correction and sign fix-up.
module mdu_div #(
  parameter int WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_is_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH:0]   r_p;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_dividend;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_zero;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic             w_accept;
  logic             w_divisor_zero;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_p_step;
  logic [WIDTH-1:0] w_q_step;
  logic [WIDTH-1:0] w_rem_mag;
  logic [WIDTH-1:0] w_quot_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_accept       = (r_state == S_IDLE) && i_start && !i_abort;
  assign w_divisor_zero = (i_divisor == {WIDTH{1'b0}});

  // Operand magnitudes; only negated for signed operations with the MSB set.
  always_comb begin
    if (i_is_signed && i_dividend[WIDTH-1]) begin
      w_dvd_mag = {WIDTH{1'b0}} - i_dividend;
    end else begin
      w_dvd_mag = i_dividend;
    end
    if (i_is_signed && i_divisor[WIDTH-1]) begin
      w_dvs_mag = {WIDTH{1'b0}} - i_divisor;
    end else begin
      w_dvs_mag = i_divisor;
    end
  end

  // One non-restoring step plus the final correction and sign application.
  // The true partial remainder stays in [-D, D), so wrapping in WIDTH+1 bits is exact.
  always_comb begin
    w_shift = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
    if (r_p[WIDTH]) begin
      w_p_step = w_shift + {1'b0, r_d};
    end else begin
      w_p_step = w_shift - {1'b0, r_d};
    end
    w_q_step = {r_q[WIDTH-2:0], ~w_p_step[WIDTH]};
    if (r_p[WIDTH]) begin
      w_rem_mag = r_p[WIDTH-1:0] + r_d;
    end else begin
      w_rem_mag = r_p[WIDTH-1:0];
    end
    if (r_neg_q) begin
      w_quot_fix = {WIDTH{1'b0}} - r_q;
    end else begin
      w_quot_fix = r_q;
    end
    if (r_neg_r) begin
      w_rem_fix = {WIDTH{1'b0}} - w_rem_mag;
    end else begin
      w_rem_fix = w_rem_mag;
    end
  end

  // Next-state logic; abort returns to IDLE from any state.
  always_comb begin
    w_state_nxt = r_state;
    if (i_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_state_nxt = w_divisor_zero ? S_FIX : S_ITER;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_ITER: begin
          if (r_cnt == LAST_CNT) begin
            w_state_nxt = S_FIX;
          end else begin
            w_state_nxt = S_ITER;
          end
        end
        S_FIX:   w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and result registers; results only change on a completed FIX.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_p        <= {(WIDTH + 1){1'b0}};
      r_q        <= {WIDTH{1'b0}};
      r_d        <= {WIDTH{1'b0}};
      r_dividend <= {WIDTH{1'b0}};
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_zero     <= 1'b0;
      r_cnt      <= {CW{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_quot     <= {WIDTH{1'b0}};
      r_rem      <= {WIDTH{1'b0}};
      r_dbz      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_abort) begin
        r_busy <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_p        <= {(WIDTH + 1){1'b0}};
              r_q        <= w_dvd_mag;
              r_d        <= w_dvs_mag;
              r_dividend <= i_dividend;
              r_neg_q    <= i_is_signed & (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
              r_neg_r    <= i_is_signed & i_dividend[WIDTH-1];
              r_zero     <= w_divisor_zero;
              r_cnt      <= {CW{1'b0}};
              r_busy     <= 1'b1;
            end else begin
              r_busy <= 1'b0;
            end
          end
          S_ITER: begin
            r_p   <= w_p_step;
            r_q   <= w_q_step;
            r_cnt <= r_cnt + CW'(1);
          end
          S_FIX: begin
            if (r_zero) begin
              r_quot <= {WIDTH{1'b1}};
              r_rem  <= r_dividend;
              r_dbz  <= 1'b1;
            end else begin
              r_quot <= w_quot_fix;
              r_rem  <= w_rem_fix;
              r_dbz  <= 1'b0;
            end
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
          default: begin
            r_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_quotient    = r_quot;
  assign o_remainder   = r_rem;
  assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_mdu_div.sv
// Directed, table-driven bench for mdu_div (WIDTH=32 and WIDTH=8 instances).
module tb_mdu_div;

  logic        clk;
  logic        rst;
  logic        start, abort, sg;
  logic [31:0] dvd, dvs;
  logic        busy, done, dbz;
  logic [31:0] quo, rem;

  logic        start8, sg8;
  logic [7:0]  dvd8, dvs8;
  logic        busy8, done8, dbz8;
  logic [7:0]  quo8, rem8;
  logic        abort8;

  int n_cmp;
  int n_fail;

  mdu_div #(.WIDTH(32)) u_dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_abort(abort), .i_is_signed(sg),
    .i_dividend(dvd), .i_divisor(dvs), .o_busy(busy), .o_done(done),
    .o_quotient(quo), .o_remainder(rem), .o_div_by_zero(dbz)
  );

  mdu_div #(.WIDTH(8)) u_dut8 (
    .i_clock(clk), .i_reset(rst), .i_start(start8), .i_abort(abort8), .i_is_signed(sg8),
    .i_dividend(dvd8), .i_divisor(dvs8), .o_busy(busy8), .o_done(done8),
    .o_quotient(quo8), .o_remainder(rem8), .o_div_by_zero(dbz8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for done; lat = edges from accept to done.
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; sg = s; dvd = a; dvs = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic do_op8(input logic s, input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    start8 = 1'b1; sg8 = s; dvd8 = a; dvs8 = b;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt;
    logic saw_done;
    n_cmp = 0; n_fail = 0;
    start = 1'b0; abort = 1'b0; sg = 1'b0; dvd = 32'd0; dvs = 32'd0;
    start8 = 1'b0; abort8 = 1'b0; sg8 = 1'b0; dvd8 = 8'd0; dvs8 = 8'd0;

    vecs[0]  = '{1'b1, 32'd100,        32'd7,          32'h0000000E, 32'h00000002, 1'b0, 33};
    vecs[1]  = '{1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33};
    vecs[2]  = '{1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2, 32'h00000002, 1'b0, 33};
    vecs[3]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'h0000000E, 32'hFFFFFFFE, 1'b0, 33};
    vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'h00000010,   32'h0FFFFFFF, 32'h0000000F, 1'b0, 33};
    vecs[5]  = '{1'b1, 32'hFFFFFFFF,   32'h00000010,   32'h00000000, 32'hFFFFFFFF, 1'b0, 33};
    vecs[6]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000, 1'b0, 33};
    vecs[7]  = '{1'b1, 32'h00001234,   32'h00000000,   32'hFFFFFFFF, 32'h00001234, 1'b1, 1};
    vecs[8]  = '{1'b0, 32'h00001234,   32'h00000000,   32'hFFFFFFFF, 32'h00001234, 1'b1, 1};
    vecs[9]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h00000000, 32'h80000000, 1'b0, 33};
    vecs[10] = '{1'b0, 32'd7,          32'd100,        32'h00000000, 32'h00000007, 1'b0, 33};

    rst = 1'b1;
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_q",    {32'd0, quo},  64'd0);
    check("reset_r",    {32'd0, rem},  64'd0);
    check("reset_dbz",  {63'd0, dbz},  64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].sg, vecs[i].a, vecs[i].b, lat, bcnt);
      check($sformatf("v%0d_lat", i),  64'(lat),  64'(vecs[i].lat));
      check($sformatf("v%0d_busy", i), 64'(bcnt), 64'(vecs[i].lat));
      check($sformatf("v%0d_q", i),    {32'd0, quo}, {32'd0, vecs[i].q});
      check($sformatf("v%0d_r", i),    {32'd0, rem}, {32'd0, vecs[i].r});
      check($sformatf("v%0d_dbz", i),  {63'd0, dbz}, {63'd0, vecs[i].z});
      check($sformatf("v%0d_busy_at_done", i), {63'd0, busy}, 64'd0);
    end

    // Second start 10 cycles into 100/7 must be ignored.
    @(negedge clk);
    start = 1'b1; sg = 1'b1; dvd = 32'd100; dvs = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    repeat (9) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    start = 1'b1; dvd = 32'd50; dvs = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; dvd = 32'd0; dvs = 32'd0;
    lat++;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    check("ignored_lat", 64'(lat), 64'd33);
    check("ignored_q", {32'd0, quo}, 64'd14);
    check("ignored_r", {32'd0, rem}, 64'd2);

    // Start issued in the done cycle is accepted.
    do_op(1'b1, 32'd50, 32'd5, lat, bcnt);
    check("b2b_lat", 64'(lat), 64'd33);
    check("b2b_q", {32'd0, quo}, 64'd10);
    check("b2b_r", {32'd0, rem}, 64'd0);

    // Abort at cycle 12: no done, previous result held.
    @(negedge clk);
    start = 1'b1; sg = 1'b1; dvd = 32'd100; dvs = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    saw_done = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
    check("abort_no_done", {63'd0, saw_done}, 64'd0);
    check("abort_q", {32'd0, quo}, 64'd10);
    check("abort_r", {32'd0, rem}, 64'd0);

    // Abort beats a simultaneous start.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; dvd = 32'd100; dvs = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", {63'd0, busy}, 64'd0);
    saw_done = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
    check("abort_start_no_done", {63'd0, saw_done}, 64'd0);

    // Reset mid-operation clears everything immediately.
    @(negedge clk);
    start = 1'b1; sg = 1'b1; dvd = 32'd100; dvs = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_q",    {32'd0, quo},  64'd0);
    check("midrst_r",    {32'd0, rem},  64'd0);
    check("midrst_dbz",  {63'd0, dbz},  64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(1'b1, 32'd9, 32'd4, lat, bcnt);
    check("post_rst_lat", 64'(lat), 64'd33);
    check("post_rst_q", {32'd0, quo}, 64'd2);
    check("post_rst_r", {32'd0, rem}, 64'd1);

    // WIDTH=8 instance.
    do_op8(1'b1, 8'd9, 8'd4, lat);
    check("w8_lat", 64'(lat), 64'd9);
    check("w8_q", {56'd0, quo8}, 64'd2);
    check("w8_r", {56'd0, rem8}, 64'd1);
    do_op8(1'b1, 8'hF7, 8'd4, lat);
    check("w8_neg_lat", 64'(lat), 64'd9);
    check("w8_neg_q", {56'd0, quo8}, 64'h00000000000000FE);
    check("w8_neg_r", {56'd0, rem8}, 64'h00000000000000FF);
    do_op8(1'b0, 8'hFF, 8'd0, lat);
    check("w8_dz_lat", 64'(lat), 64'd1);
    check("w8_dz_q", {56'd0, quo8}, 64'h00000000000000FF);
    check("w8_dz_dbz", {63'd0, dbz8}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
